// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline (IF/DE/EX/MEM/WB).
// Detects load-use hazards, flushes wrong-path instructions on a taken branch,
// selects EX forwarding sources and freezes the pipeline while data memory
// is busy. A stall that outlasts the timeout parks the block in a sticky error
// state until reset.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   de_ir_i                    instruction currently in DE
//   ex_rs1_i/ex_rs2_i/ex_rd_i  register fields of the EX instruction
//   ex_mem_read_i              EX instruction is a load
//   ex_br_taken_i              branch/jump in EX resolved taken
//   mem_rd_i/mem_reg_write_i   destination and write flag of MEM instruction
//   wb_rd_i/wb_reg_write_i     destination and write flag of WB instruction
//   dmem_req_i/dmem_ready_i    data memory handshake from MEM stage
//   *_we_o                     pipeline register write enables
//   if_de_flush_o/de_ex_flush_o load a NOP into IF/DE or DE/EX
//   fwd_a_o/fwd_b_o            EX operand select: 00 regfile, 01 MEM, 10 WB
//   err_o                      sticky memory-timeout error
//   stall_cnt_o/flush_cnt_o    saturating stall and flush cycle counters
module pipeline_hazard_ctrl #(
  parameter int unsigned MemTimeout = 15,
  parameter int unsigned CntW       = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [31:0]     de_ir_i,
  input  logic [4:0]      ex_rs1_i,
  input  logic [4:0]      ex_rs2_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_mem_read_i,
  input  logic            ex_br_taken_i,
  input  logic [4:0]      mem_rd_i,
  input  logic            mem_reg_write_i,
  input  logic [4:0]      wb_rd_i,
  input  logic            wb_reg_write_i,
  input  logic            dmem_req_i,
  input  logic            dmem_ready_i,
  output logic            pc_we_o,
  output logic            if_de_we_o,
  output logic            de_ex_we_o,
  output logic            ex_mem_we_o,
  output logic            mem_wb_we_o,
  output logic            if_de_flush_o,
  output logic            de_ex_flush_o,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o,
  output logic            err_o,
  output logic [CntW-1:0] stall_cnt_o,
  output logic [CntW-1:0] flush_cnt_o
);

  localparam int unsigned WaitW = (MemTimeout < 2) ? 1 : $clog2(MemTimeout + 1);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MemTimeout);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StRun, StMemWait, StErrHalt} state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CntW-1:0]   flush_cnt_q, flush_cnt_d;

  logic [6:0] opcode;
  logic [4:0] de_rs1, de_rs2;
  logic       use_rs1, use_rs2, load_use, freeze;

  // DE decode: only the register fields an opcode actually reads count as uses.
  assign opcode  = de_ir_i[6:0];
  assign de_rs1  = de_ir_i[19:15];
  assign de_rs2  = de_ir_i[24:20];
  assign use_rs1 = (opcode != OpLui) && (opcode != OpAuipc) && (opcode != OpJal);
  assign use_rs2 = (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);

  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((use_rs1 && (ex_rd_i == de_rs1)) || (use_rs2 && (ex_rd_i == de_rs2)));

  // A ready response in MEM_WAIT releases the freeze in the same cycle.
  assign freeze = (state_q == StErrHalt) ||
                  ((state_q == StRun) && dmem_req_i && !dmem_ready_i) ||
                  ((state_q == StMemWait) && !dmem_ready_i);

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] mrd,
                                         input logic mwr, input logic [4:0] wrd,
                                         input logic wwr);
    if (mwr && (mrd != 5'd0) && (mrd == rs)) begin
      return 2'b01;
    end else if (wwr && (wrd != 5'd0) && (wrd == rs)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (dmem_req_i && !dmem_ready_i) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (dmem_ready_i) begin
          state_d = StRun;
        end else if (wait_cnt_q == TimeoutVal) begin
          state_d = StErrHalt;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StErrHalt: state_d = StErrHalt;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze || (load_use && !ex_br_taken_i)) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end else if (ex_br_taken_i) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_comb begin
    pc_we_o       = 1'b1;
    if_de_we_o    = 1'b1;
    de_ex_we_o    = 1'b1;
    ex_mem_we_o   = 1'b1;
    mem_wb_we_o   = 1'b1;
    if_de_flush_o = 1'b0;
    de_ex_flush_o = 1'b0;
    fwd_a_o       = fwd_sel(ex_rs1_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);
    fwd_b_o       = fwd_sel(ex_rs2_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);
    err_o         = rst_ni && (state_q == StErrHalt);
    if (!rst_ni) begin
      {pc_we_o, if_de_we_o, de_ex_we_o, ex_mem_we_o, mem_wb_we_o} = 5'b00000;
      if_de_flush_o = 1'b1;
      de_ex_flush_o = 1'b1;
      fwd_a_o       = 2'b00;
      fwd_b_o       = 2'b00;
    end else if (freeze) begin
      {pc_we_o, if_de_we_o, de_ex_we_o, ex_mem_we_o, mem_wb_we_o} = 5'b00000;
    end else if (ex_br_taken_i) begin
      // DE holds a wrong-path instruction, so any load-use match is moot.
      if_de_flush_o = 1'b1;
      de_ex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_we_o       = 1'b0;
      if_de_we_o    = 1'b0;
      de_ex_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table,
// memory-stall / timeout sequences and randomized traffic against a model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MemTimeout = 15;
  localparam int unsigned CntW       = 6;
  localparam int          CntMax     = (1 << CntW) - 1;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpImm    = 7'b0010011;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     de_ir;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic            ex_mem_read, ex_br_taken, mem_rw, wb_rw, dmem_req, dmem_ready;
  logic            pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we;
  logic            if_de_flush, de_ex_flush, err;
  logic [1:0]      fwd_a, fwd_b;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic [4:0]      we_v;
  logic [1:0]      fl_v;

  assign we_v = {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we};
  assign fl_v = {if_de_flush, de_ex_flush};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MemTimeout(MemTimeout),
    .CntW      (CntW)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .de_ir_i        (de_ir),
    .ex_rs1_i       (ex_rs1),
    .ex_rs2_i       (ex_rs2),
    .ex_rd_i        (ex_rd),
    .ex_mem_read_i  (ex_mem_read),
    .ex_br_taken_i  (ex_br_taken),
    .mem_rd_i       (mem_rd),
    .mem_reg_write_i(mem_rw),
    .wb_rd_i        (wb_rd),
    .wb_reg_write_i (wb_rw),
    .dmem_req_i     (dmem_req),
    .dmem_ready_i   (dmem_ready),
    .pc_we_o        (pc_we),
    .if_de_we_o     (if_de_we),
    .de_ex_we_o     (de_ex_we),
    .ex_mem_we_o    (ex_mem_we),
    .mem_wb_we_o    (mem_wb_we),
    .if_de_flush_o  (if_de_flush),
    .de_ex_flush_o  (de_ex_flush),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: memory-wait bookkeeping and counter totals.
  bit m_err, m_wait;
  int m_waited, m_stall, m_flush;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  function automatic int fwd_m(input logic [4:0] rs);
    if (mem_rw && mem_rd != 0 && mem_rd == rs) return 1;
    if (wb_rw && wb_rd != 0 && wb_rd == rs) return 2;
    return 0;
  endfunction

  // One clock: predict outputs from model + current inputs, compare, then
  // advance the model across the rising edge.
  task automatic step(input string nm);
    logic [6:0] op;
    bit u1, u2, lu, frz;
    int ewe, efl, efa, efb;
    op  = de_ir[6:0];
    u1  = !(op == OpLui || op == OpAuipc || op == OpJal);
    u2  = (op == OpReg || op == OpStore || op == OpBranch);
    lu  = ex_mem_read && ex_rd != 0 &&
          ((u1 && ex_rd == de_ir[19:15]) || (u2 && ex_rd == de_ir[24:20]));
    frz = m_err || (!dmem_ready && (m_wait || dmem_req));
    efa = fwd_m(ex_rs1);
    efb = fwd_m(ex_rs2);
    if (!rst_n) begin
      ewe = 0; efl = 3; efa = 0; efb = 0;
    end else if (frz) begin
      ewe = 0; efl = 0;
    end else if (ex_br_taken) begin
      ewe = 31; efl = 3;
    end else if (lu) begin
      ewe = 7; efl = 1;
    end else begin
      ewe = 31; efl = 0;
    end
    #3;
    chk({nm, " we"}, we_v, ewe);
    chk({nm, " flush"}, fl_v, efl);
    chk({nm, " fwd_a"}, fwd_a, efa);
    chk({nm, " fwd_b"}, fwd_b, efb);
    chk({nm, " err"}, err, (m_err && rst_n) ? 1 : 0);
    chk({nm, " stall_cnt"}, stall_cnt, m_stall);
    chk({nm, " flush_cnt"}, flush_cnt, m_flush);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_err = 0; m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (frz || (lu && !ex_br_taken)) begin
        if (m_stall < CntMax) m_stall++;
      end else if (ex_br_taken) begin
        if (m_flush < CntMax) m_flush++;
      end
      if (!m_err) begin
        if (!m_wait) begin
          if (dmem_req && !dmem_ready) begin
            m_wait = 1; m_waited = 0;
          end
        end else if (dmem_ready) begin
          m_wait = 0;
        end else if (m_waited == int'(MemTimeout)) begin
          m_wait = 0; m_err = 1;
        end else begin
          m_waited++;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    de_ir = mk(OpImm, 5'd0, 5'd0, 5'd0);
    {ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_mem_read, ex_br_taken, mem_rw, wb_rw, dmem_req} = '0;
    dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step("reset");
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [4:0]  rs1, rs2, rd;
    logic        mr, br;
    logic [4:0]  mrd;
    logic        mrw;
    logic [4:0]  wrd;
    logic        wrw;
    logic [4:0]  we;
    logic [1:0]  fl, fa, fb;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{mk(OpReg, 5, 7, 6), 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b00111, 2'b01, 0, 0};
    tbl[1]  = '{mk(OpLui, 5, 5, 5), 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0};
    tbl[2]  = '{mk(OpReg, 0, 0, 6), 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0};
    tbl[3]  = '{mk(OpReg, 1, 5, 6), 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b00111, 2'b01, 0, 0};
    tbl[4]  = '{mk(OpImm, 1, 5, 6), 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0};
    tbl[5]  = '{mk(OpStore, 1, 5, 0), 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b00111, 2'b01, 0, 0};
    tbl[6]  = '{mk(OpReg, 5, 7, 6), 0, 0, 5, 1, 1, 0, 0, 0, 0, 5'b11111, 2'b11, 0, 0};
    tbl[7]  = '{mk(OpImm, 0, 0, 0), 3, 3, 0, 0, 0, 3, 1, 3, 1, 5'b11111, 2'b00, 1, 1};
    tbl[8]  = '{mk(OpImm, 0, 0, 0), 3, 3, 0, 0, 0, 3, 0, 3, 1, 5'b11111, 2'b00, 2, 2};
    tbl[9]  = '{mk(OpImm, 0, 0, 0), 0, 3, 0, 0, 0, 0, 1, 3, 1, 5'b11111, 2'b00, 0, 2};
    tbl[10] = '{mk(OpJal, 5, 5, 1), 4, 3, 5, 1, 0, 4, 1, 3, 1, 5'b11111, 2'b00, 1, 2};
    tbl[11] = '{mk(OpBranch, 2, 5, 0), 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b00111, 2'b01, 0, 0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_err = 0; m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    do_reset();

    // Directed decode/forwarding vectors.
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      de_ir = tbl[i].ir; ex_rs1 = tbl[i].rs1; ex_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
      ex_mem_read = tbl[i].mr; ex_br_taken = tbl[i].br;
      mem_rd = tbl[i].mrd; mem_rw = tbl[i].mrw; wb_rd = tbl[i].wrd; wb_rw = tbl[i].wrw;
      #2;
      chk($sformatf("vec%0d we", i), we_v, tbl[i].we);
      chk($sformatf("vec%0d flush", i), fl_v, tbl[i].fl);
      chk($sformatf("vec%0d fwd_a", i), fwd_a, tbl[i].fa);
      chk($sformatf("vec%0d fwd_b", i), fwd_b, tbl[i].fb);
      step($sformatf("vec%0d", i));
    end
    // Stalls: vec0, vec3, vec5, vec11; flush: vec6 (lu ignored there).
    chk("table stall_cnt", stall_cnt, 4);
    chk("table flush_cnt", flush_cnt, 1);

    // Memory not ready for 4 cycles, then ready.
    do_reset();
    dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dmem_ready = (i == 4);
      #2;
      chk($sformatf("memwait%0d we", i), we_v, (i == 4) ? 31 : 0);
      step($sformatf("memwait%0d", i));
    end
    dmem_req = 1'b0;
    chk("memwait stall_cnt", stall_cnt, 4);
    chk("memwait err", err, 0);

    // Freeze holds a pending taken branch; it applies once memory is ready.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_br_taken = 1'b1;
    step("frzbr0");
    dmem_ready = 1'b1;
    step("frzbr1");
    chk("frzbr flush_cnt", flush_cnt, 1);
    chk("frzbr stall_cnt", stall_cnt, 1);

    // Timeout into sticky error, counter saturation, then reset recovery.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 75; i++) begin
      #2;
      chk($sformatf("timeout%0d err", i), err, (i >= int'(MemTimeout) + 2) ? 1 : 0);
      step($sformatf("timeout%0d", i));
    end
    chk("saturated stall_cnt", stall_cnt, CntMax);
    do_reset();
    chk("post-reset err", err, 0);
    chk("post-reset stall_cnt", stall_cnt, 0);
    chk("post-reset flush_cnt", flush_cnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] ops [7];
      ops = '{OpLui, OpAuipc, OpJal, OpReg, OpStore, OpBranch, OpImm};
      rst_n       = ($urandom_range(0, 59) != 0);
      de_ir       = mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      ex_rs1      = 5'($urandom_range(0, 3));
      ex_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 5) == 0);
      mem_rd      = 5'($urandom_range(0, 3));
      mem_rw      = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 3));
      wb_rw       = 1'($urandom_range(0, 1));
      dmem_req    = ($urandom_range(0, 3) == 0);
      dmem_ready  = (i % 100 >= 70) ? 1'b0 : ($urandom_range(0, 2) != 0);
      step($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
